// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder request scheduler.
package adder_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Requester index width; never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority at ptr, wrapping N-1 -> 0.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = idw_f(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   winner,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW:0] cand;

  // Walk from the farthest slot back to ptr so the closest requester wins last.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(N)) begin
        cand = cand - (IDW + 1)'(N);
      end
      if (req[cand[IDW-1:0]]) begin
        idx = cand[IDW-1:0];
      end
    end
    winner = {{(N - 1){1'b0}}, any} << idx;
  end

endmodule

// File: rtl/adder_req_scheduler.sv
// Shares one registered adder between N requesters with round-robin grants,
// tagged responses and a watchdog for a silent or spurious adder.
module adder_req_scheduler
  import adder_sched_pkg::*;
#(
  parameter int W       = 20,
  parameter int N       = 4,
  parameter int TIMEOUT = 4,
  localparam int IDW    = idw_f(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_y,
  output logic           add_start,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  input  logic           add_valid,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] cur_id_reg, cur_id_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   gnt_next;
  logic           add_start_next, rsp_valid_next, err_next;
  logic [W-1:0]   add_a_next, add_b_next, rsp_y_next;
  logic [IDW-1:0] rsp_id_next;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic [N-1:0]   arb_winner;
  logic [IDW-1:0] arb_idx;
  logic           arb_any;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  rr_arbiter #(.N(N)) u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (arb_winner),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cur_id_next    = cur_id_reg;
    cnt_next       = cnt_reg;
    gnt_next       = '0;
    add_start_next = 1'b0;
    add_a_next     = add_a;
    add_b_next     = add_b;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id;
    rsp_y_next     = rsp_y;
    err_next       = err;
    case (state_reg)
      IDLE: begin
        // A result with no operation outstanding means the adder misbehaved.
        if (add_valid) begin
          err_next = 1'b1;
        end
        if (arb_any) begin
          gnt_next       = arb_winner;
          add_start_next = 1'b1;
          add_a_next     = a_arr[arb_idx];
          add_b_next     = b_arr[arb_idx];
          cur_id_next    = arb_idx;
          ptr_next       = (arb_idx == IDW'(N - 1)) ? '0 : arb_idx + IDW'(1);
          cnt_next       = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        // A late valid on the watchdog's final cycle still counts as a result.
        if (add_valid) begin
          rsp_valid_next = 1'b1;
          rsp_y_next     = add_y;
          rsp_id_next    = cur_id_reg;
          state_next     = IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      cur_id_reg <= '0;
      cnt_reg    <= '0;
      gnt        <= '0;
      add_start  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_y      <= '0;
      err        <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      cur_id_reg <= cur_id_next;
      cnt_reg    <= cnt_next;
      gnt        <= gnt_next;
      add_start  <= add_start_next;
      add_a      <= add_a_next;
      add_b      <= add_b_next;
      rsp_valid  <= rsp_valid_next;
      rsp_id     <= rsp_id_next;
      rsp_y      <= rsp_y_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_adder_req_scheduler.sv
// Randomized bench for adder_req_scheduler with a latency-configurable adder
// model and a schedule-level reference (rr order, 3-cycle ops, modular sums).
module tb_adder_req_scheduler;

  localparam int W       = 20;
  localparam int N       = 4;
  localparam int TIMEOUT = 4;
  localparam int IDW     = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;
  logic           add_start;
  logic [W-1:0]   add_a, add_b;
  logic [W-1:0]   add_y     = '0;
  logic           add_valid = 1'b0;
  logic           err;

  logic           adder_en = 1'b1;
  logic           inj      = 1'b0;
  int             lat      = 0;
  logic           start_pipe [8];
  logic [W-1:0]   sum_pipe   [8];

  int n_cmp     = 0;
  int n_bad     = 0;
  int model_ptr = 0;

  adder_req_scheduler #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .add_valid (add_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Registered adder with extra latency 'lat'; 'adder_en' silences it, 'inj' forces valid.
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      start_pipe[i] = start_pipe[i-1];
      sum_pipe[i]   = sum_pipe[i-1];
    end
    start_pipe[0] = add_start;
    sum_pipe[0]   = add_a + add_b;
    #1;
    add_valid = (adder_en & start_pipe[lat]) | inj;
    add_y     = sum_pipe[lat];
  end

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % (longint'(1) << W);
    return W'(s);
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return W'(1) << (W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== '0)       begin n_bad++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    n_cmp++; if (add_start !== 0)  begin n_bad++; $display("FAIL reset_add_start: got %b want 0", add_start); end
    n_cmp++; if (add_a !== '0)     begin n_bad++; $display("FAIL reset_add_a: got %h want 0", add_a); end
    n_cmp++; if (add_b !== '0)     begin n_bad++; $display("FAIL reset_add_b: got %h want 0", add_b); end
    n_cmp++; if (rsp_valid !== 0)  begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== '0)    begin n_bad++; $display("FAIL reset_rsp_id: got %h want 0", rsp_id); end
    n_cmp++; if (rsp_y !== '0)     begin n_bad++; $display("FAIL reset_rsp_y: got %h want 0", rsp_y); end
    n_cmp++; if (err !== 0)        begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n     = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    $display("reset: released, outputs checked");
  endtask

  // One request pattern driven for 'cycles' then drained; every cycle checked.
  task automatic run_traffic(input string name, input int cycles, input bit hold_all);
    int e, next_ok, rsp_due, w, exp_id;
    logic [W-1:0]   exp_y;
    logic [N-1:0]   req_seen, exp_gnt;
    logic [N*W-1:0] a_seen, b_seen;
    e = 0; next_ok = 0; rsp_due = -1; exp_id = 0; exp_y = '0;
    for (int c = 0; c < cycles + 4; c++) begin
      req_seen = req; a_seen = req_a; b_seen = req_b;
      @(negedge clk);
      e++;
      w = (e >= next_ok && req_seen != '0) ? rr_pick(model_ptr, req_seen) : -1;
      exp_gnt = (w >= 0) ? N'(1 << w) : '0;
      n_cmp++; if (gnt !== exp_gnt) begin n_bad++; $display("FAIL %s_gnt: cycle %0d got %b want %b", name, e, gnt, exp_gnt); end
      if (w >= 0) begin
        n_cmp++;
        if (add_a !== a_seen[w*W +: W] || add_b !== b_seen[w*W +: W] || add_start !== 1'b1) begin
          n_bad++; $display("FAIL %s_issue: cycle %0d got a=%h b=%h st=%b want a=%h b=%h st=1", name, e, add_a, add_b, add_start, a_seen[w*W +: W], b_seen[w*W +: W]);
        end
        model_ptr = (w + 1) % N;
        next_ok   = e + 3;
        rsp_due   = e + 2;
        exp_id    = w;
        exp_y     = exp_sum(a_seen[w*W +: W], b_seen[w*W +: W]);
        $display("%s: cycle %0d grant %0d a=%h b=%h", name, e, w, a_seen[w*W +: W], b_seen[w*W +: W]);
      end
      n_cmp++; if (rsp_valid !== (e == rsp_due)) begin n_bad++; $display("FAIL %s_rsp_valid: cycle %0d got %b want %b", name, e, rsp_valid, e == rsp_due); end
      if (e == rsp_due) begin
        n_cmp++;
        if (rsp_id !== IDW'(exp_id) || rsp_y !== exp_y) begin
          n_bad++; $display("FAIL %s_rsp: cycle %0d got id=%0d y=%h want id=%0d y=%h", name, e, rsp_id, rsp_y, exp_id, exp_y);
        end
        $display("%s: cycle %0d response id=%0d y=%h", name, e, rsp_id, rsp_y);
      end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s_err: cycle %0d got %b want 0", name, e, err); end
      if (c >= cycles - 1) begin
        req = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (w == i) begin
            if (hold_all || $urandom_range(0, 1) == 1) set_op(i, rand_op(), rand_op());
            else req[i] = 1'b0;
            if (hold_all) req[i] = 1'b1;
          end else if (!req[i] && $urandom_range(0, 2) == 0) begin
            set_op(i, rand_op(), rand_op());
            req[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_all_held();
    for (int i = 0; i < N; i++) set_op(i, rand_op(), rand_op());
    req = '1;
    run_traffic("all_held", 15, 1'b1);
  endtask

  task automatic test_random_traffic();
    run_traffic("random", 60, 1'b0);
  endtask

  // Drives one request set and checks its grant and the response two cycles later.
  task automatic test_one_op(input string name, input logic [N-1:0] r);
    int w;
    logic [W-1:0] a, b;
    w = rr_pick(model_ptr, r);
    a = req_a[w*W +: W];
    b = req_b[w*W +: W];
    req = r;
    @(negedge clk);
    n_cmp++; if (gnt !== N'(1 << w) || add_start !== 1'b1) begin n_bad++; $display("FAIL %s_gnt: got %b st=%b want %b st=1", name, gnt, add_start, N'(1 << w)); end
    n_cmp++; if (add_a !== a || add_b !== b) begin n_bad++; $display("FAIL %s_operands: got %h %h want %h %h", name, add_a, add_b, a, b); end
    req = '0;
    model_ptr = (w + 1) % N;
    @(negedge clk);
    n_cmp++; if (gnt !== '0 || add_start !== 1'b0 || rsp_valid !== 1'b0 || add_a !== a) begin n_bad++; $display("FAIL %s_wait: got gnt=%b st=%b rv=%b a=%h want 0 0 0 %h", name, gnt, add_start, rsp_valid, add_a, a); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_y !== exp_sum(a, b)) begin
      n_bad++; $display("FAIL %s_rsp: got v=%b id=%0d y=%h want v=1 id=%0d y=%h", name, rsp_valid, rsp_id, rsp_y, w, exp_sum(a, b));
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_rsp_pulse: got %b want 0", name, rsp_valid); end
    $display("%s: grant %0d a=%h b=%h y=%h", name, w, a, b, rsp_y);
  endtask

  task automatic test_single();
    set_op(2, W'(100), W'(23));
    test_one_op("single", 4'b0100);
    n_cmp++; if (rsp_y !== W'(123)) begin n_bad++; $display("FAIL single_sum: got %0d want 123", rsp_y); end
  endtask

  task automatic test_wrap();
    set_op(0, W'(1) << (W - 1), W'(1) << (W - 1));
    test_one_op("wrap", 4'b0001);
    n_cmp++; if (rsp_y !== '0) begin n_bad++; $display("FAIL wrap_sum: got %h want 0", rsp_y); end
  endtask

  task automatic test_timeout();
    adder_en = 1'b0;
    set_op(1, rand_op(), rand_op());
    req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (gnt !== N'(1 << rr_pick(model_ptr, 4'b0010))) begin n_bad++; $display("FAIL timeout_gnt: got %b want 0010", gnt); end
    model_ptr = 2;
    set_op(3, rand_op(), rand_op());
    req = 4'b1000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== '0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_quiet: wait %0d got gnt=%b rv=%b want 0 0", k, gnt, rsp_valid); end
      n_cmp++; if (err !== (k == TIMEOUT)) begin n_bad++; $display("FAIL timeout_err: wait %0d got %b want %b", k, err, k == TIMEOUT); end
    end
    $display("timeout: err=%b after %0d wait cycles", err, TIMEOUT);
    adder_en = 1'b1;
    req = 4'b0000;
    test_one_op("after_timeout", 4'b1000);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_wait();
    set_op(1, rand_op(), rand_op());
    req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (gnt !== N'(1 << rr_pick(model_ptr, 4'b0010))) begin n_bad++; $display("FAIL midrst_gnt: got %b", gnt); end
    req   = '0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== '0 || add_start !== 1'b0 || add_a !== '0 || add_b !== '0) begin n_bad++; $display("FAIL midrst_issue_clear: got gnt=%b st=%b a=%h b=%h want 0", gnt, add_start, add_a, add_b); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_y !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL midrst_rsp_clear: got rv=%b id=%0d y=%h err=%b want 0", rsp_valid, rsp_id, rsp_y, err); end
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || gnt !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp: cycle %0d got rv=%b gnt=%b err=%b want 0", k, rsp_valid, gnt, err); end
    end
    $display("reset_mid_wait: op discarded, ptr back to 0");
    set_op(1, rand_op(), rand_op());
    set_op(3, rand_op(), rand_op());
    test_one_op("ptr_after_reset", 4'b1010);
    test_one_op("req3_after_reset", 4'b1000);
  endtask

  task automatic test_valid_vs_timeout();
    int i;
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    lat = TIMEOUT - 2;
    i = $urandom_range(0, N - 1);
    a = rand_op(); b = rand_op();
    set_op(i, a, b);
    req = N'(1 << i);
    @(negedge clk);
    n_cmp++; if (gnt !== N'(1 << i)) begin n_bad++; $display("FAIL late_gnt: got %b want %b", gnt, N'(1 << i)); end
    model_ptr = (i + 1) % N;
    req = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== (k == TIMEOUT)) begin n_bad++; $display("FAIL late_rsp_valid: wait %0d got %b want %b", k, rsp_valid, k == TIMEOUT); end
    end
    n_cmp++; if (rsp_id !== IDW'(i) || rsp_y !== exp_sum(a, b) || err !== 1'b0) begin
      n_bad++; $display("FAIL late_rsp: got id=%0d y=%h err=%b want id=%0d y=%h err=0", rsp_id, rsp_y, err, i, exp_sum(a, b));
    end
    $display("valid_vs_timeout: id=%0d y=%h err=%b", rsp_id, rsp_y, err);
    lat = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_valid();
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL spurious_early: got %b want 0", err); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (err !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL spurious_err: cycle %0d got err=%b rv=%b want 1 0", k, err, rsp_valid); end
    end
    $display("spurious_valid: err=%b rsp_valid=%b", err, rsp_valid);
    set_op(2, rand_op(), rand_op());
    test_one_op("after_spurious", 4'b0100);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      start_pipe[i] = 1'b0;
      sum_pipe[i]   = '0;
    end
    test_reset();
    test_all_held();
    test_single();
    test_wrap();
    test_random_traffic();
    test_timeout();
    test_reset_mid_wait();
    test_valid_vs_timeout();
    test_spurious_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
